multicycle_control_fsm: RTL and testbench

- Multi-cycle instruction sequencer for the processor ISA: ADD, AND, MOVL, MOVS, JA, CMP.
- Replaces one-shot ROM decode with an FSM that steps through fetch, decode, execute, memory and writeback.
- Handshakes with instruction and data memories.
- Sits between the IR opcode field and the datapath (PC, register file, ALU, flags, memory).

---
 rtl/multicycle_control_fsm_pkg.sv | 36 +++
 rtl/multicycle_control_fsm_opcode_class_decode.sv | 26 ++
 rtl/multicycle_control_fsm.sv | 153 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared opcode map, ALU encodings, sequencer states and opcode class bundle.
package multicycle_control_fsm_pkg;

    localparam int unsigned OPC_ADD  = 4;
    localparam int unsigned OPC_AND  = 25;
    localparam int unsigned OPC_MOVL = 11;
    localparam int unsigned OPC_MOVS = 13;
    localparam int unsigned OPC_JA   = 14;
    localparam int unsigned OPC_CMP  = 59;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_SUB = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic is_alu;
        logic is_cmp;
        logic is_ja;
        logic is_load;
        logic is_store;
        logic legal;
    } opc_class_t;

endpackage

// File: rtl/multicycle_control_fsm_opcode_class_decode.sv
// Combinational opcode classifier; shared by the single- and multi-cycle paths.
module multicycle_control_fsm_opcode_class_decode
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output opc_class_t       cls
);

    logic [2**OPC_W-1:0] onehot;

    // Each opcode selects one bit of the decode space; classes OR their bits.
    assign onehot = (2**OPC_W)'(1) << opcode;

    always_comb begin
        cls          = '0;
        cls.is_alu   = onehot[OPC_ADD] | onehot[OPC_AND];
        cls.is_cmp   = onehot[OPC_CMP];
        cls.is_ja    = onehot[OPC_JA];
        cls.is_load  = onehot[OPC_MOVL];
        cls.is_store = onehot[OPC_MOVS];
        cls.legal    = cls.is_alu | cls.is_cmp | cls.is_ja | cls.is_load | cls.is_store;
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer: fetch/decode/exec/mem/writeback with memory handshakes,
// data-memory timeout, sticky fault flags and a retired-instruction counter.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OPC_W       = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             flag_above,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             mem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             flags_we,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_we,
    output logic             reg_src,
    output logic             illegal,
    output logic             mem_fault,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e           state;
    logic [OPC_W-1:0] opc_q;
    logic [OPC_W-1:0] dec_opc;
    logic [WAIT_W-1:0] wait_cnt;
    opc_class_t       cls;

    // The IR field is only trusted in DECODE; later states use the captured copy.
    assign dec_opc = (state == ST_DECODE) ? opcode : opc_q;

    multicycle_control_fsm_opcode_class_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode (dec_opc),
        .cls    (cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            opc_q       <= '0;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            mem_fault   <= 1'b0;
            retired_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) state <= ST_DECODE;
                end
                ST_DECODE: begin
                    opc_q <= opcode;
                    if (cls.legal) begin
                        state <= ST_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= ST_HALT;
                    end
                end
                ST_EXEC: begin
                    if (cls.is_cmp || cls.is_ja) begin
                        retired_cnt <= retired_cnt + 1'b1;
                        state       <= ST_FETCH;
                    end else if (cls.is_load || cls.is_store) begin
                        wait_cnt <= '0;
                        state    <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    // An ack on the final allowed cycle still completes the access.
                    if (mem_ack) begin
                        if (cls.is_load) begin
                            state <= ST_WB;
                        end else begin
                            retired_cnt <= retired_cnt + 1'b1;
                            state       <= ST_FETCH;
                        end
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        mem_fault <= 1'b1;
                        state     <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    retired_cnt <= retired_cnt + 1'b1;
                    state       <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        alu_op    = ALU_ADD;
        alu_src   = 1'b0;
        flags_we  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_we    = 1'b0;
        reg_src   = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
                pc_we    = imem_ack;
            end
            ST_EXEC: begin
                if (cls.is_alu) begin
                    alu_op = (opc_q == OPC_W'(OPC_AND)) ? ALU_AND : ALU_ADD;
                end else if (cls.is_cmp) begin
                    alu_op   = ALU_SUB;
                    flags_we = 1'b1;
                end else if (cls.is_ja) begin
                    pc_we  = flag_above;
                    pc_sel = flag_above;
                end else if (cls.is_load || cls.is_store) begin
                    alu_src = 1'b1;
                end
            end
            ST_MEM: begin
                mem_read  = cls.is_load;
                mem_write = cls.is_store;
            end
            ST_WB: begin
                reg_we  = 1'b1;
                reg_src = cls.is_load;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed and random instructions checked
// against an instruction-level model of cycle counts, strobe totals and counters.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = '0;
    logic        flag_above = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        mem_ack = 1'b0;
    logic        ir_we, pc_we, pc_sel;
    logic [1:0]  alu_op;
    logic        alu_src, flags_we, mem_read, mem_write, reg_we, reg_src;
    logic        illegal, mem_fault;
    logic [15:0] retired_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cur_opc = 0;
    logic [15:0] exp_ret = '0;
    bit          exp_ill = 1'b0;
    bit          exp_flt = 1'b0;

    logic [5:0]  legal_ops [6] = '{6'd4, 6'd25, 6'd11, 6'd13, 6'd14, 6'd59};

    multicycle_control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .flag_above  (flag_above),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .mem_ack     (mem_ack),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .flags_we    (flags_we),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_we      (reg_we),
        .reg_src     (reg_src),
        .illegal     (illegal),
        .mem_fault   (mem_fault),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s (opcode %0d): observed %0h expected %0h", tag, cur_opc, got, exp);
        end
    endtask

    function automatic logic [13:0] strobes();
        return {imem_req, ir_we, pc_we, pc_sel, alu_op, alu_src, flags_we,
                mem_read, mem_write, reg_we, reg_src, 2'b00};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("reset_strobes", 64'(strobes()), 64'd0);
        check("reset_sticky", 64'({illegal, mem_fault}), 64'd0);
        check("reset_retired", 64'(retired_cnt), 64'd0);
        exp_ret = '0;
        exp_ill = 1'b0;
        exp_flt = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_strobes", 64'(strobes()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; ack_dly = low mem_ack cycles in MEM.
    task automatic run_instr(input logic [5:0] opc, input bit flag, input int fetch_dly,
                             input int ack_dly, output bit halted);
        int cyc = 0, fetch_seen = 0, mem_seen = 0, after = -1;
        int n_req = 0, n_ir = 0, n_pc = 0, n_br = 0, n_rd = 0, n_wr = 0, n_reg = 0, n_flg = 0;
        logic [1:0] ex_op = '0;
        logic ex_src = 1'b0, wb_src = 1'b0;
        bit done = 1'b0, saw_fetch = 1'b0;
        bit is_add, is_and, is_movl, is_movs, is_ja, is_cmp, legal, mem, tmo, halt, wr_reg;
        int mcyc;

        is_add  = (opc == 6'd4);
        is_and  = (opc == 6'd25);
        is_movl = (opc == 6'd11);
        is_movs = (opc == 6'd13);
        is_ja   = (opc == 6'd14);
        is_cmp  = (opc == 6'd59);
        legal   = is_add | is_and | is_movl | is_movs | is_ja | is_cmp;
        mem     = is_movl | is_movs;
        tmo     = mem && (ack_dly >= 15);
        mcyc    = tmo ? 15 : ack_dly + 1;
        halt    = !legal || tmo;
        wr_reg  = is_add | is_and | (is_movl & !tmo);

        cur_opc = int'(opc);
        opcode = opc;
        flag_above = flag;
        while (!done) begin
            imem_ack = (after < 0) && (fetch_seen >= fetch_dly);
            mem_ack = (mem_seen >= ack_dly);
            if (after >= 1) opcode = 6'($urandom);
            @(negedge clk);
            if (after >= 0 && imem_req) begin
                saw_fetch = 1'b1;
                done = 1'b1;
            end else begin
                cyc++;
                n_req += int'(imem_req);
                n_ir  += int'(ir_we);
                n_pc  += int'(pc_we);
                n_br  += int'(pc_we & pc_sel);
                n_rd  += int'(mem_read);
                n_wr  += int'(mem_write);
                n_reg += int'(reg_we);
                n_flg += int'(flags_we);
                if (after == 1) begin
                    ex_op = alu_op;
                    ex_src = alu_src;
                end
                if (reg_we) wb_src = reg_src;
                check("excl_rd_wr", 64'(mem_read & mem_write), 64'd0);
                check("excl_reg_wr", 64'(reg_we & mem_write), 64'd0);
                fetch_seen += int'(imem_req);
                mem_seen += int'(mem_read | mem_write);
                if (ir_we) after = 0;
                else if (after >= 0) after++;
                if (after > 40 || cyc > 300) done = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        if (!legal) exp_ill = 1'b1;
        if (tmo) exp_flt = 1'b1;
        if (!halt) exp_ret = exp_ret + 16'd1;

        check("next_fetch", 64'(saw_fetch), 64'(!halt));
        if (!halt)
            check("cycles", 64'(cyc), 64'(fetch_dly + 3 + (mem ? mcyc : 0) + ((is_add | is_and | is_movl) ? 1 : 0)));
        check("imem_req_cycles", 64'(n_req), 64'(fetch_dly + 1));
        check("ir_we_count", 64'(n_ir), 64'd1);
        check("branch_count", 64'(n_br), 64'(is_ja & flag));
        check("pc_we_count", 64'(n_pc), 64'(1 + int'(is_ja & flag)));
        check("mem_read_cycles", 64'(n_rd), 64'(is_movl ? mcyc : 0));
        check("mem_write_cycles", 64'(n_wr), 64'(is_movs ? mcyc : 0));
        check("reg_we_count", 64'(n_reg), 64'(wr_reg));
        check("flags_we_count", 64'(n_flg), 64'(is_cmp));
        if (legal && !is_ja) begin
            check("exec_alu_op", 64'(ex_op), 64'(is_and ? 2'b01 : (is_cmp ? 2'b10 : 2'b00)));
            check("exec_alu_src", 64'(ex_src), 64'(mem));
        end
        if (wr_reg) check("wb_reg_src", 64'(wb_src), 64'(is_movl));
        check("illegal", 64'(illegal), 64'(exp_ill));
        check("mem_fault", 64'(mem_fault), 64'(exp_flt));
        check("retired_cnt", 64'(retired_cnt), 64'(exp_ret));
        halted = halt;
    endtask

    initial begin
        bit h;
        logic [5:0] opc;
        int ad;

        do_reset();

        run_instr(6'd4, 1'b0, 0, 0, h);
        run_instr(6'd59, 1'b0, 0, 0, h);
        run_instr(6'd14, 1'b1, 0, 0, h);
        run_instr(6'd59, 1'b0, 0, 0, h);
        run_instr(6'd14, 1'b0, 0, 0, h);
        run_instr(6'd25, 1'b1, 2, 0, h);
        run_instr(6'd11, 1'b0, 0, 3, h);
        run_instr(6'd13, 1'b0, 1, 0, h);
        run_instr(6'd11, 1'b0, 0, 14, h);

        // Reset while a load waits in MEM.
        cur_opc = 11;
        opcode = 6'd11;
        imem_ack = 1'b1;
        mem_ack = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid_mem_read", 64'(mem_read), 64'd1);
        do_reset();
        run_instr(6'd4, 1'b0, 0, 0, h);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) opc = 6'($urandom);
            else opc = legal_ops[$urandom_range(0, 5)];
            case ($urandom_range(0, 19))
                0: ad = 100;
                1: ad = 14;
                default: ad = $urandom_range(0, 4);
            endcase
            run_instr(opc, 1'($urandom), $urandom_range(0, 3), ad, h);
            if (h) do_reset();
        end

        run_instr(6'd4, 1'b0, 0, 0, h);
        run_instr(6'd13, 1'b0, 0, 100, h);
        @(negedge clk);
        check("halt_strobes", 64'(strobes()), 64'd0);
        @(posedge clk);
        #1;
        do_reset();

        run_instr(6'd0, 1'b0, 0, 0, h);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
